seq_sum_led: RTL

- Parametrised, clocked successor to the team's combinational 3-bit LED adder.
- Captures two WIDTH-bit operands on a rising edge of START and adds them bit-serially, one bit per clock.
- Shows the operands while idle and the result plus a done flag while START stays high, all on one LED bank.
- Sits between the board switches/button and the LED bank.

---
 rtl/seq_sum_pkg.sv | 39 +++
 rtl/seq_sum_led_if.sv | 37 +++
 rtl/sync_rise.sv | 38 +++
 rtl/seq_sum_led.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_sum_pkg.sv
// Shared types and LED field helpers for the bit-serial LED adder.
// Contents: FSM state enum, LED field offsets, led_pack() field assembler.
// Optional subtract mode is selected elsewhere by macro SEQ_SUM_SUB_EN.
package seq_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SHOW = 2'd2
  } state_e;

  // Widest operand led_pack() can assemble; the LED bank is 2*WIDTH+2 bits.
  localparam int unsigned MAX_W  = 32;
  localparam int unsigned PACK_W = 2 * MAX_W + 2;

  // Field positions: done at 2*WIDTH+DONE_BIT, carry at 2*WIDTH+CARRY_BIT,
  // upper field starting at WIDTH+UPPER_LSB, lower field at bit 0.
  localparam int unsigned DONE_BIT  = 1;
  localparam int unsigned CARRY_BIT = 0;
  localparam int unsigned UPPER_LSB = 0;

  // Assemble {done, carry, upper, lower} for a w-bit field width.
  // upper/lower must already be zero-extended from w bits.
  function automatic logic [PACK_W-1:0] led_pack(
    input int unsigned     w,
    input logic            done,
    input logic            carry,
    input logic [MAX_W-1:0] upper,
    input logic [MAX_W-1:0] lower
  );
    logic [PACK_W-1:0] r;
    r = PACK_W'(lower);
    r = r | (PACK_W'(upper) << (w + UPPER_LSB));
    r = r | (PACK_W'(carry) << (2 * w + CARRY_BIT));
    r = r | (PACK_W'(done)  << (2 * w + DONE_BIT));
    return r;
  endfunction

endpackage

// File: rtl/seq_sum_led_if.sv
// Switch/button/LED bundle between the board and seq_sum_led.
// Signals: START (button level), A/B (operand switches), LED (display bank),
// BUSY (serial add running), DONE (result shown). SUB exists only when
// SEQ_SUM_SUB_EN is defined. master = board side, slave = adder side.
interface seq_sum_led_if #(
  parameter int unsigned WIDTH = 3
) ();

  localparam int unsigned LED_W = 2 * WIDTH + 2;

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [LED_W-1:0] LED;
  logic             BUSY;
  logic             DONE;
`ifdef SEQ_SUM_SUB_EN
  logic             SUB;
`endif

  modport master (
`ifdef SEQ_SUM_SUB_EN
    output SUB,
`endif
    output START, A, B,
    input  LED, BUSY, DONE
  );

  modport slave (
`ifdef SEQ_SUM_SUB_EN
    input  SUB,
`endif
    input  START, A, B,
    output LED, BUSY, DONE
  );

endinterface

// File: rtl/sync_rise.sv
// Two-flop synchroniser plus rising-edge detect for the START button.
// Ports: clk_i, rst_ni (synchronous, active-low), async_i (raw level),
// level_o (synchronised level s2), rise_o (s2 & ~s3, armed).
module sync_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;
  logic vld_q;
  logic armed_q;

  // armed_q: a press only counts once the button has been seen low after
  // reset, so holding START through reset does not launch an add.
  // vld_q marks that s1 holds a real sample rather than its reset value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= 1'b1;
      armed_q <= armed_q | (vld_q & ~s1_q);
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q & armed_q;

endmodule

// File: rtl/seq_sum_led.sv
// Bit-serial WIDTH-bit adder driving a single LED bank.
// Idle: LED shows {0,0,A,B}. A START rise captures A/B and adds them one
// bit per clock (BUSY high, LED dark); the result {1,carry,0..0,sum} is then
// held while START stays high.
// Ports: CLK, RST_N (synchronous, active-low), bus (seq_sum_led_if.slave:
// START, A, B in; LED, BUSY, DONE out).
// Macro SEQ_SUM_SUB_EN adds bus.SUB: when latched high the unit computes
// A-B and the carry LED shows the borrow.
module seq_sum_led
  import seq_sum_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  seq_sum_led_if.slave bus
);

  localparam int unsigned     LED_W    = 2 * WIDTH + 2;
  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned     DONE_IDX = 2 * WIDTH + DONE_BIT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             busy_q, busy_d;

  logic start_lvl;
  logic start_rise;
  logic sub_in;
  logic b_bit, s_bit, c_bit;

  // Button synchroniser and press detect.
  sync_rise u_sync (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .async_i (bus.START),
    .level_o (start_lvl),
    .rise_o  (start_rise)
  );

`ifdef SEQ_SUM_SUB_EN
  assign sub_in = bus.SUB;
`else
  assign sub_in = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, serial full adder and LED image.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    busy_d  = 1'b0;

    // Subtraction is A + ~B + 1: invert B here, initial carry set at capture.
    b_bit = b_q[0] ^ sub_q;
    s_bit = a_q[0] ^ b_bit ^ carry_q;
    c_bit = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);

    unique case (state_q)
      IDLE: begin
        led_d = LED_W'(led_pack(WIDTH, 1'b0, 1'b0,
                                MAX_W'(bus.A), MAX_W'(bus.B)));
        if (start_rise) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sub_d   = sub_in;
          carry_d = sub_in;
          sum_d   = '0;
          cnt_d   = '0;
          led_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end

      ADD: begin
        // LSB first: sum bit enters at the MSB and walks down.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        carry_d = c_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        led_d   = '0;
        busy_d  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Borrow is the inverted carry in subtract mode.
          led_d   = LED_W'(led_pack(WIDTH, 1'b1, c_bit ^ sub_q,
                                    '0, MAX_W'(sum_d)));
          busy_d  = 1'b0;
          state_d = SHOW;
        end
      end

      SHOW: begin
        led_d = LED_W'(led_pack(WIDTH, 1'b1, carry_q ^ sub_q,
                                '0, MAX_W'(sum_q)));
        if (!start_lvl) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.LED  = led_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = led_q[DONE_IDX];

endmodule
